addsub_rr_sched: RTL and testbench

//  Shares one carry-lookahead add/sub datapath among N requesters.
//  - Round-robin arbitration over valid/ready request ports.
//  - Each accepted operation is computed in one cycle and held in a single output register.
//  - The result is returned with the requester id over a valid/ready response port.
//  - Sits between the ALU issue logic and the shared CLA adder tree (W=8, 9, 10 or 25 variants).

---
 rtl/addsub_rr_sched_pkg.sv | 24 ++
 rtl/addsub_core.sv | 40 ++++
 rtl/addsub_rr_sched.sv | 120 ++++++++++++
 tb/tb_addsub_rr_sched.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_rr_sched_pkg.sv
// Shared definitions for the round-robin add/sub scheduler: default widths and op encoding.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package addsub_rr_sched_pkg;

    localparam int W_DEF    = 8;    // operand/result width
    localparam int N_DEF    = 4;    // number of requesters
    localparam int CNTW_DEF = 16;   // completed-operation counter width

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Result flags kept beside the sum in the output register.
    typedef struct packed {
        logic cout;     // carry out; for subtract 1 = no borrow
        logic ovf;      // two's-complement overflow
    } rsp_flags_t;

    // Requester id width; at least one bit so a port of width zero never appears.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational add/subtract: sum = a + (b ^ {W{sub}}) + sub, with carry out and signed overflow.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
//
// Ports:
//   a, b  operands
//   sub   OP_SUB selects a-b, OP_ADD selects a+b
//   sum   result modulo 2^W
//   cout  carry out of bit W-1 (for subtract: 1 = no borrow)
//   ovf   two's-complement overflow
module addsub_core
    import addsub_rr_sched_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    logic         sub_en;
    logic [W-1:0] bx;
    logic [W:0]   full;

    assign sub_en = (sub == OP_SUB);

    // Subtract is a + ~b + 1: invert b and feed the op bit in as carry-in.
    assign bx   = b ^ {W{sub_en}};
    assign full = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub_en};

    assign sum  = full[W-1:0];
    assign cout = full[W];

    // Overflow when both effective operands share a sign and the result's sign differs.
    assign ovf  = (a[W-1] == bx[W-1]) & (sum[W-1] != a[W-1]);

endmodule

// File: rtl/addsub_rr_sched.sv
// Round-robin scheduler sharing one add/sub datapath among N valid/ready requesters.
// Latency: 1 cycle from request handshake to rsp_valid; sustains 1 op/clk.
// Backpressure: req_ready drops to 0 while a held result is not taken (rsp_valid & ~rsp_ready).
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready [N]    per-requester handshake; req_ready is one-hot or zero
//   req_a/req_b [N*W]          operands, requester i at [i*W +: W]
//   req_sub [N]                1 = A-B, 0 = A+B
//   rsp_valid/rsp_ready        result handshake
//   rsp_id/sum/cout/ovf        registered result and the requester that issued it
//   op_cnt                     saturating count of rsp handshakes
module addsub_rr_sched
    import addsub_rr_sched_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int N    = N_DEF,
    parameter int CNTW = CNTW_DEF,
    parameter int IDW  = id_width(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [N*W-1:0]  req_a,
    input  logic [N*W-1:0]  req_b,
    input  logic [N-1:0]    req_sub,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IDW-1:0]  rsp_id,
    output logic [W-1:0]    rsp_sum,
    output logic            rsp_cout,
    output logic            rsp_ovf,
    output logic [CNTW-1:0] op_cnt
);

    logic [IDW-1:0] ptr;
    logic           grant_vld;
    logic [IDW-1:0] grant_id;
    logic [N-1:0]   grant_oh;
    logic           accept;
    logic           take;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           op_sub;
    logic [W-1:0]   core_sum;
    rsp_flags_t     core_flags;
    rsp_flags_t     rsp_flags;

    // Output register is free when empty or being drained on this edge.
    assign accept = ~rsp_valid | rsp_ready;

    // Search ptr, ptr+1, ... mod N. Walking the offsets from the far end lets the
    // nearest valid requester overwrite any farther one, so the first hit wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
    end

    assign grant_oh  = N'(1) << grant_id;
    assign take      = rst_n & accept & grant_vld;
    assign req_ready = take ? grant_oh : '0;

    // Operand mux for the granted requester.
    assign op_a   = req_a[int'(grant_id)*W +: W];
    assign op_b   = req_b[int'(grant_id)*W +: W];
    assign op_sub = req_sub[grant_id];

    addsub_core #(
        .W (W)
    ) u_core (
        .a    (op_a),
        .b    (op_b),
        .sub  (op_sub),
        .sum  (core_sum),
        .cout (core_flags.cout),
        .ovf  (core_flags.ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_flags <= '0;
            ptr       <= '0;
            op_cnt    <= '0;
        end else begin
            // A new grant refills the register even while the old result drains.
            if (take) begin
                rsp_valid <= 1'b1;
                rsp_id    <= grant_id;
                rsp_sum   <= core_sum;
                rsp_flags <= core_flags;
                ptr       <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            if (rsp_valid && rsp_ready && (op_cnt != {CNTW{1'b1}})) begin
                op_cnt <= op_cnt + 1'b1;
            end
        end
    end

    assign rsp_cout = rsp_flags.cout;
    assign rsp_ovf  = rsp_flags.ovf;

endmodule

// File: tb/tb_addsub_rr_sched.sv
module tb_addsub_rr_sched;

    localparam int W    = 8;
    localparam int N    = 4;
    localparam int CNTW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic [N-1:0]    req_sub;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [W-1:0]    rsp_sum;
    logic            rsp_cout;
    logic            rsp_ovf;
    logic [CNTW-1:0] op_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: rotation pointer, output slot contents, counter.
    int m_ptr  = 0;
    bit m_vld  = 0;
    int m_id   = 0;
    int m_sum  = 0;
    bit m_cout = 0;
    bit m_ovf  = 0;
    int m_cnt  = 0;

    always #5 clk = ~clk;

    addsub_rr_sched #(
        .W    (W),
        .N    (N),
        .CNTW (CNTW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .op_cnt    (op_cnt)
    );

    // First valid requester in rotation order starting at the pointer, or -1.
    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int g;
        g = model_grant();
        if (rst_n !== 1'b1) return '0;
        if (m_vld && !rsp_ready) return '0;
        if (g < 0) return '0;
        return N'(1 << g);
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int g, a, b, r, sa, sb, sr;
        bit s, acc;
        if (!rst_n) begin
            m_ptr = 0; m_vld = 0; m_id = 0; m_sum = 0;
            m_cout = 0; m_ovf = 0; m_cnt = 0;
            return;
        end
        g   = model_grant();
        acc = !m_vld || rsp_ready;
        if (m_vld && rsp_ready && m_cnt != 65535) m_cnt++;
        if (acc && g >= 0) begin
            a  = int'(req_a[g*W +: W]);
            b  = int'(req_b[g*W +: W]);
            s  = req_sub[g];
            sa = (a >= 128) ? a - 256 : a;
            sb = (b >= 128) ? b - 256 : b;
            if (s) begin
                r = a - b;  m_cout = (a >= b);   sr = sa - sb;
            end else begin
                r = a + b;  m_cout = (r >= 256); sr = sa + sb;
            end
            m_sum = r & 255;
            m_ovf = (sr > 127) || (sr < -128);
            m_id  = g;
            m_vld = 1;
            m_ptr = (g + 1) % N;
        end else if (m_vld && rsp_ready) begin
            m_vld = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_ops();
        req_a   = $urandom;
        req_b   = $urandom;
        req_sub = N'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 1'b0;
        rand_ops();
        #1;
        vectors++;
        if (req_ready !== 4'h0) begin
            miscompares++; $display("FAIL reset_req_ready: got %h want 0", req_ready);
        end
        tick(); tick();
        vectors++;
        if (rsp_valid !== 1'b0 || op_cnt !== 16'h0 || rsp_sum !== 8'h0 || rsp_id !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b cnt=%h sum=%h id=%0d want 0/0/0/0", rsp_valid, op_cnt, rsp_sum, rsp_id);
        end
        rst_n = 1'b1; rsp_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++; $display("FAIL reset_first_grant: got %b want 0001", req_ready);
        end
        req_valid = 4'h0;
        tick();
    endtask

    task automatic test_add_ovf();
        req_valid = 4'b0001; rsp_ready = 1'b1; req_sub = 4'b0000;
        req_a[7:0] = 8'h7F; req_b[7:0] = 8'h01;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++; $display("FAIL add_ready: got %b want 0001", req_ready);
        end
        tick();
        vectors++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== {1'b1, 2'd0, 8'h80, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL add_ovf: got v=%b id=%0d sum=%h c=%b o=%b want 1/0/80/0/1", rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf);
        end
        req_valid = 4'h0;
        tick();
        vectors++;
        if (rsp_valid !== 1'b0 || op_cnt !== 16'd1) begin
            miscompares++; $display("FAIL add_drain: got v=%b cnt=%0d want 0/1", rsp_valid, op_cnt);
        end
    endtask

    task automatic test_sub();
        req_valid = 4'b0100; rsp_ready = 1'b1; req_sub = 4'b0100;
        req_a[23:16] = 8'h05; req_b[23:16] = 8'h07;
        #1;
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++; $display("FAIL sub_ready: got %b want 0100", req_ready);
        end
        tick();
        vectors++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== {1'b1, 2'd2, 8'hFE, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL sub_borrow: got v=%b id=%0d sum=%h c=%b o=%b want 1/2/fe/0/0", rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf);
        end
        req_a[23:16] = 8'h80; req_b[23:16] = 8'h01;
        #1;
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++; $display("FAIL sub_refill_ready: got %b want 0100", req_ready);
        end
        tick();
        vectors++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== {1'b1, 2'd2, 8'h7F, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL sub_ovf: got v=%b id=%0d sum=%h c=%b o=%b want 1/2/7f/1/1", rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf);
        end
        req_valid = 4'h0;
        tick();
        vectors++;
        if (rsp_valid !== 1'b0 || op_cnt !== 16'd3) begin
            miscompares++; $display("FAIL sub_drain: got v=%b cnt=%0d want 0/3", rsp_valid, op_cnt);
        end
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0; req_valid = 4'h0;
        tick();
        rst_n = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rand_ops();
            #1;
            vectors++;
            if (req_ready !== N'(1 << (k % N))) begin
                miscompares++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, N'(1 << (k % N)));
            end
            tick();
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % N) || op_cnt !== 16'(k)) begin
                miscompares++;
                $display("FAIL rr_seq[%0d]: got v=%b id=%0d cnt=%0d want 1/%0d/%0d", k, rsp_valid, rsp_id, op_cnt, k % N, k);
            end
            vectors++;
            if ({rsp_sum, rsp_cout, rsp_ovf} !== {8'(m_sum), m_cout, m_ovf}) begin
                miscompares++;
                $display("FAIL rr_arith[%0d]: got sum=%h c=%b o=%b want %h/%b/%b", k, rsp_sum, rsp_cout, rsp_ovf, m_sum, m_cout, m_ovf);
            end
        end
    endtask

    task automatic test_backpressure();
        int held_sum;
        bit held_c, held_o;
        held_sum = m_sum; held_c = m_cout; held_o = m_ovf;
        rsp_ready = 1'b0; req_valid = 4'hF;
        for (int k = 0; k < 3; k++) begin
            rand_ops();
            #1;
            vectors++;
            if (req_ready !== 4'h0) begin
                miscompares++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, req_ready);
            end
            tick();
            vectors++;
            if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, op_cnt} !== {1'b1, 2'd0, 8'(held_sum), held_c, held_o, 16'd4}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%0d sum=%h cnt=%0d want 1/0/%h/4", k, rsp_valid, rsp_id, rsp_sum, op_cnt, held_sum);
            end
        end
        rsp_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++; $display("FAIL bp_release_ready: got %b want 0010", req_ready);
        end
        tick();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || op_cnt !== 16'd5) begin
            miscompares++; $display("FAIL bp_release: got v=%b id=%0d cnt=%0d want 1/1/5", rsp_valid, rsp_id, op_cnt);
        end
    endtask

    task automatic test_reset_midop();
        rst_n = 1'b0; rsp_ready = 1'b0; req_valid = 4'hF;
        #1;
        vectors++;
        if (req_ready !== 4'h0) begin
            miscompares++; $display("FAIL midrst_ready: got %b want 0000", req_ready);
        end
        tick();
        vectors++;
        if (rsp_valid !== 1'b0 || op_cnt !== 16'd0) begin
            miscompares++; $display("FAIL midrst_state: got v=%b cnt=%0d want 0/0", rsp_valid, op_cnt);
        end
        rst_n = 1'b1; req_valid = 4'b1010;
        #1;
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++; $display("FAIL midrst_grant: got %b want 0010", req_ready);
        end
        tick();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
            miscompares++; $display("FAIL midrst_rsp: got v=%b id=%0d want 1/1", rsp_valid, rsp_id);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst_n     = ($urandom_range(0, 40) != 0);
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rand_ops();
            #1;
            vectors++;
            if (req_ready !== model_ready()) begin
                miscompares++; $display("FAIL rand_ready[%0d]: got %b want %b", n, req_ready, model_ready());
            end
            tick();
            vectors++;
            if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, op_cnt} !==
                {m_vld, 2'(m_id), 8'(m_sum), m_cout, m_ovf, 16'(m_cnt)}) begin
                miscompares++;
                $display("FAIL rand_rsp[%0d]: got v=%b id=%0d sum=%h c=%b o=%b cnt=%0d want %b/%0d/%h/%b/%b/%0d",
                         n, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, op_cnt,
                         m_vld, m_id, m_sum, m_cout, m_ovf, m_cnt);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_sub = '0;
        test_reset();
        test_add_ovf();
        test_sub();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
